// File: rtl/long_prim_seq.sv
// Stimulus sequencer for the XOR/NOT primitive chain: drives LFSR vectors,
// waits a settle time, checks each result against a closed form and signs it.
module long_prim_seq #(
    parameter int          IO_PAIRS = 4,
    parameter int          DEPTH    = 8,
    parameter int          NUM_VEC  = 16,
    parameter int          SETTLE   = 2,
    parameter logic [31:0] SEED     = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [2*IO_PAIRS-1:0] dut_in,
    input  logic [2*IO_PAIRS-1:0] dut_out,
    output logic [15:0]           vec_count,
    output logic [15:0]           err_count,
    output logic [15:0]           first_err,
    output logic [2*IO_PAIRS-1:0] signature
);

    localparam int          W    = 2 * IO_PAIRS;
    localparam logic [31:0] MASK = 32'h8020_0003;
    localparam logic [1:0]  DEP  = 2'(DEPTH % 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  dut_in_q, dut_in_d;
    logic [15:0]   vec_q, vec_d;
    logic [15:0]   err_q, err_d;
    logic [15:0]   first_q, first_d;
    logic [W-1:0]  sig_q, sig_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic [7:0]    cnt_q, cnt_d;

    logic [W-1:0]  exp_v;
    logic [15:0]   vec_inc;
    logic [31:0]   lfsr_nx;
    logic          in_run;

    // Only DEPTH mod 4 matters: the chain collapses to this per-lane form.
    always_comb begin
        exp_v = '0;
        for (int j = 0; j < IO_PAIRS; j++) begin
            exp_v[2*j]   = dut_in_q[2*j] ^ DEP[0];
            exp_v[2*j+1] = dut_in_q[2*j+1] ^ DEP[1]
                         ^ (DEP[0] & dut_in_q[2*j]);
        end
    end

    assign vec_inc = vec_q + 16'd1;
    assign lfsr_nx = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : 32'h0);
    assign in_run  = (state_q == S_APPLY) || (state_q == S_SETTLE)
                  || (state_q == S_CHECK);

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dut_in_d = dut_in_q;
        vec_d    = vec_q;
        err_d    = err_q;
        first_d  = first_q;
        sig_d    = sig_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d   = '0;
                    err_d   = '0;
                    sig_d   = '0;
                    first_d = 16'hFFFF;
                    lfsr_d  = SEED;
                    busy_d  = 1'b1;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                dut_in_d = lfsr_q[W-1:0];
                cnt_d    = 8'(SETTLE);
                state_d  = (SETTLE > 0) ? S_SETTLE : S_CHECK;
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (dut_out != exp_v) begin
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    if (first_q == 16'hFFFF) first_d = vec_q;
                end
                sig_d  = {sig_q[W-2:0], sig_q[W-1]} ^ dut_out;
                vec_d  = vec_inc;
                lfsr_d = lfsr_nx;
                if (vec_inc == 16'(NUM_VEC)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_APPLY;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort beats completion; the CHECK updates above still land.
        if (abort && in_run) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dut_in_q <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            first_q  <= 16'hFFFF;
            sig_q    <= '0;
            lfsr_q   <= SEED;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dut_in_q <= dut_in_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            first_q  <= first_d;
            sig_q    <= sig_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dut_in    = dut_in_q;
    assign vec_count = vec_q;
    assign err_count = err_q;
    assign first_err = first_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_long_prim_seq.sv
// Bench for long_prim_seq: four parameterisations against a behavioural
// chain model, LFSR sequence and signature scoreboard.
module tb_long_prim_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_a;
    logic start_a, abort_a, start_bc, start_d, no_abort;
    logic [3:0] cur_vec;
    logic [7:0] inj [16];

    logic        busy_a, done_a, busy_b, done_b;
    logic        busy_c, done_c, busy_d, done_d;
    logic [7:0]  din_a, dout_a, sig_a, din_b, dout_b, sig_b;
    logic [7:0]  din_c, dout_c, sig_c, din_d, dout_d, sig_d;
    logic [15:0] vc_a, ec_a, fe_a, vc_b, ec_b, fe_b;
    logic [15:0] vc_c, ec_c, fe_c, vc_d, ec_d, fe_d;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] lstep(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [7:0] din_of(input int k);
        logic [31:0] l;
        l = 32'h1;
        for (int i = 0; i < k; i++) l = lstep(l);
        return l[7:0];
    endfunction

    function automatic logic [7:0] chain(input logic [7:0] d, input int depth);
        logic [1:0] dp;
        logic [7:0] r;
        dp = 2'(depth % 4);
        for (int j = 0; j < 4; j++) begin
            r[2*j]   = d[2*j] ^ dp[0];
            r[2*j+1] = d[2*j+1] ^ dp[1] ^ (dp[0] & d[2*j]);
        end
        return r;
    endfunction

    assign dout_a = chain(din_a, 3) ^ inj[cur_vec];
    assign dout_b = din_b;
    assign dout_c = din_c;
    assign dout_d = chain(din_d, 3);

    long_prim_seq #(.IO_PAIRS(4), .DEPTH(3), .NUM_VEC(16), .SETTLE(2)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .dut_in(din_a), .dut_out(dout_a),
        .vec_count(vc_a), .err_count(ec_a), .first_err(fe_a),
        .signature(sig_a));

    long_prim_seq #(.IO_PAIRS(4), .DEPTH(8), .NUM_VEC(16), .SETTLE(2)) u_b (
        .clk(clk), .rst(rst), .start(start_bc), .abort(no_abort),
        .busy(busy_b), .done(done_b), .dut_in(din_b), .dut_out(dout_b),
        .vec_count(vc_b), .err_count(ec_b), .first_err(fe_b),
        .signature(sig_b));

    long_prim_seq #(.IO_PAIRS(4), .DEPTH(1), .NUM_VEC(16), .SETTLE(2)) u_c (
        .clk(clk), .rst(rst), .start(start_bc), .abort(no_abort),
        .busy(busy_c), .done(done_c), .dut_in(din_c), .dut_out(dout_c),
        .vec_count(vc_c), .err_count(ec_c), .first_err(fe_c),
        .signature(sig_c));

    long_prim_seq #(.IO_PAIRS(4), .DEPTH(3), .NUM_VEC(1), .SETTLE(0)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .abort(no_abort),
        .busy(busy_d), .done(done_d), .dut_in(din_d), .dut_out(dout_d),
        .vec_count(vc_d), .err_count(ec_d), .first_err(fe_d),
        .signature(sig_d));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard over the first m vectors of a run.
    task automatic model(input int depth, input bit ident, input int m,
                         output logic [15:0] vc, output logic [15:0] ec,
                         output logic [15:0] fe, output logic [7:0] sg);
        logic [31:0] l;
        logic [7:0]  d, o;
        l  = 32'h1;
        vc = 16'(m);
        ec = '0;
        fe = 16'hFFFF;
        sg = '0;
        for (int k = 0; k < m; k++) begin
            d = l[7:0];
            o = ident ? d : (chain(d, depth) ^ inj[k]);
            if (o != chain(d, depth)) begin
                if (fe == 16'hFFFF) fe = 16'(k);
                ec++;
            end
            sg = {sg[6:0], sg[7]} ^ o;
            l  = lstep(l);
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_din"}, din_a, 0);
        chk({tag, "_vc"}, vc_a, 0);
        chk({tag, "_ec"}, ec_a, 0);
        chk({tag, "_fe"}, fe_a, 16'hFFFF);
        chk({tag, "_sig"}, sig_a, 0);
    endtask

    // mode 0: full run (extra start during vector 8), 1: abort, 2: reset
    task automatic run_a(input int mode, input int cut);
        logic [15:0] evc, eec, efe;
        logic [7:0]  esg;
        bit last;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cur_vec = 4'(k);
            start_a = (mode == 0 && k == 8);
            if (mode == 1 && k == cut) begin
                @(posedge clk);
                #1 abort_a = 1'b1;
                @(posedge clk);
                #1 abort_a = 1'b0;
                chk("abort_busy", busy_a, 0);
                repeat (3) begin
                    @(posedge clk);
                    #1 chk("abort_done", done_a, 0);
                end
                model(3, 0, cut, evc, eec, efe, esg);
                chk("abort_vc", vc_a, evc);
                chk("abort_ec", ec_a, eec);
                chk("abort_fe", fe_a, efe);
                chk("abort_sig", sig_a, esg);
                return;
            end
            if (mode == 2 && k == cut) begin
                @(posedge clk);
                #2 rst_a = 1'b1;
                #1 chk_reset_a("midrst");
                @(negedge clk) rst_a = 1'b0;
                repeat (2) @(posedge clk);
                #1 chk_reset_a("postrst");
                return;
            end
            for (int j = 0; j < 4; j++) begin
                @(posedge clk);
                #1;
                last = (k == 15 && j == 3);
                chk("busy", busy_a, !last);
                chk("done", done_a, last);
                if (j == 0) chk("dut_in", din_a, din_of(k));
            end
        end
        start_a = 1'b0;
        @(posedge clk);
        #1 chk("done_pulse", done_a, 0);
        chk("idle_busy", busy_a, 0);
        model(3, 0, 16, evc, eec, efe, esg);
        chk("vec_count", vc_a, evc);
        chk("err_count", ec_a, eec);
        chk("first_err", fe_a, efe);
        chk("signature", sig_a, esg);
    endtask

    initial begin
        logic [15:0] evc, eec, efe;
        logic [7:0]  esg;
        rst = 1'b1;
        rst_a = 1'b1;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_bc = 1'b0;
        start_d = 1'b0;
        no_abort = 1'b0;
        cur_vec = '0;
        for (int i = 0; i < 16; i++) inj[i] = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset_a("reset");
        @(negedge clk);
        rst = 1'b0;
        rst_a = 1'b0;

        // identity tie: DEPTH=8 matches, DEPTH=1 never matches
        @(negedge clk) start_bc = 1'b1;
        @(posedge clk);
        #1 start_bc = 1'b0;
        repeat (63) @(posedge clk);
        #1 chk("b_early", done_b, 0);
        @(posedge clk);
        #1 chk("b_done", done_b, 1);
        chk("c_done", done_c, 1);
        model(8, 1, 16, evc, eec, efe, esg);
        chk("b_ec", ec_b, eec);
        chk("b_fe", fe_b, efe);
        chk("b_sig", sig_b, esg);
        model(1, 1, 16, evc, eec, efe, esg);
        chk("c_ec", ec_c, eec);
        chk("c_fe", fe_c, efe);
        chk("c_vc", vc_c, evc);

        // SETTLE=0, one vector, start held through busy and DONE
        @(negedge clk) start_d = 1'b1;
        @(posedge clk);
        #1 chk("d_apply", {busy_d, done_d}, 2'b10);
        @(posedge clk);
        #1 chk("d_check", {busy_d, done_d}, 2'b10);
        @(posedge clk);
        #1 chk("d_done", {busy_d, done_d}, 2'b01);
        @(posedge clk);
        #1 chk("d_idle", {busy_d, done_d}, 2'b00);
        start_d = 1'b0;
        @(posedge clk);
        #1 chk("d_norerun", {busy_d, done_d}, 2'b00);
        model(3, 0, 1, evc, eec, efe, esg);
        chk("d_vc", vc_d, evc);
        chk("d_ec", ec_d, eec);
        chk("d_fe", fe_d, efe);
        chk("d_sig", sig_d, esg);

        run_a(0, 0);
        chk("vec0_din", din_of(0), 8'h01);
        inj[5] = 8'h01;
        inj[9] = 8'h01;
        run_a(0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++)
                inj[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            run_a(0, 0);
        end
        for (int i = 0; i < 16; i++) inj[i] = '0;
        run_a(1, 3);
        run_a(0, 0);
        run_a(2, 7);
        run_a(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
